// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and word helpers for the key schedule.
package aes_pkg;

    // Round count for AES-128.
    localparam int unsigned NR = 10;

    // Round constants, indexed by the round number that consumes them.
    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        StIdle,
        StExpand,
        StEmit
    } state_e;

    // Cyclic left rotation of a word by one byte.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Multiply by x in GF(2^8), reduced with the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    // Row 0 of the table sits in the most significant bits.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry n lives at bit offset 8*(255-n), and 255-n is ~n for a byte.
    always_comb begin
        data_o = SBOX[{~data_i, 3'b000} +: 8];
    end

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 decryption round-key generator: expands forward to round key 10,
// then steps the schedule backwards, presenting keys 10..0 on a ready/valid port.
module aes_inv_key_sched #(
    parameter int unsigned NR    = 10,  // only 10 is legal
    parameter int unsigned KEY_W = 128  // only 128 is legal
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid_in,
    input  logic [KEY_W-1:0] cipher_key,
    output logic             key_ready,
    output logic [KEY_W-1:0] round_key,
    output logic [3:0]       rk_index,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             rk_last,
    output logic             busy
);

    import aes_pkg::*;

    state_e           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic [7:0]       rcon_q, rcon_d;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] inv_w1, inv_w2, inv_w3, inv_w0;
    logic [31:0] fwd_w0, fwd_w1, fwd_w2, fwd_w3;
    logic [31:0] sub_in, rot_w, sub_w, mix_w;
    logic [7:0]  rcon_byte;
    logic [3:0]  rcon_idx;

    // Split the key register into words, w0 in the most significant position.
    always_comb begin
        w0 = key_q[127:96];
        w1 = key_q[95:64];
        w2 = key_q[63:32];
        w3 = key_q[31:0];
    end

    // Shared SubWord path: forward step feeds w3, inverse step feeds the recovered w3.
    always_comb begin
        inv_w3    = w3 ^ w2;
        inv_w2    = w2 ^ w1;
        inv_w1    = w1 ^ w0;
        sub_in    = (state_q == StEmit) ? inv_w3 : w3;
        rot_w     = rot_word(sub_in);
        // Index 0 never reaches the mix since no step is taken at round 0.
        rcon_idx  = (idx_q == 4'd0) ? 4'd1 : idx_q;
        rcon_byte = (state_q == StEmit) ? RCON[rcon_idx] : rcon_q;
        mix_w     = sub_w ^ {rcon_byte, 24'h000000};
        inv_w0    = w0 ^ mix_w;
        fwd_w0    = w0 ^ mix_w;
        fwd_w1    = w1 ^ fwd_w0;
        fwd_w2    = w2 ^ fwd_w1;
        fwd_w3    = w3 ^ fwd_w2;
    end

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .data_i (rot_w[8*i +: 8]),
            .data_o (sub_w[8*i +: 8])
        );
    end

    // Next-state logic: accept, forward expansion, then backward walk.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        unique case (state_q)
            StIdle: begin
                if (key_valid_in) begin
                    key_d   = cipher_key;
                    cnt_d   = 4'd1;
                    rcon_d  = 8'h01;
                    state_d = StExpand;
                end
            end
            StExpand: begin
                key_d  = {fwd_w0, fwd_w1, fwd_w2, fwd_w3};
                rcon_d = xtime(rcon_q);
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'(NR)) begin
                    idx_d   = 4'(NR);
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (rk_ready) begin
                    if (idx_q == 4'd0) begin
                        state_d = StIdle;
                    end else begin
                        key_d = {inv_w0, inv_w1, inv_w2, inv_w3};
                        idx_d = idx_q - 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with asynchronous abort to the idle values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            key_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            rcon_q  <= 8'h01;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
        end
    end

    // Outputs decoded from state; the key is only visible while it is valid.
    always_comb begin
        key_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        rk_valid  = (state_q == StEmit);
        round_key = rk_valid ? key_q : '0;
        rk_index  = idx_q;
        rk_last   = rk_valid && (idx_q == 4'd0);
    end

endmodule
